blast_seed_scanner: RTL and testbench

Sequencing controller for the 11-base word-match datapath in the BLAST accelerator. Loads one 11-base query word, accepts a 2-bit-per-base database stream, keeps an 11-base sliding window, and forms the per-base equality vector that feeds the 11-input AND match reduction. Matching window start positions are queued in a small hit FIFO and drained to the host-side PCIe/Qsys logic over a valid/ready interface, with backpressure to the database stream.

---
 rtl/blast_seed_scanner_if.sv | 22 ++
 rtl/blast_seed_scanner.sv | 136 +++++++++++++
 tb/tb_blast_seed_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/blast_seed_scanner_if.sv
// Stream-side handshakes of the seed scanner: the database base stream in,
// the hit position stream out.
interface blast_seed_scanner_if #(
    parameter int POS_W = 32
) ();
    logic             db_valid;
    logic [1:0]       db_base;
    logic             db_ready;
    logic             hit_valid;
    logic [POS_W-1:0] hit_pos;
    logic             hit_ready;

    modport master (
        output db_valid, db_base, hit_ready,
        input  db_ready, hit_valid, hit_pos
    );

    modport slave (
        input  db_valid, db_base, hit_ready,
        output db_ready, hit_valid, hit_pos
    );
endinterface

// File: rtl/blast_seed_scanner.sv
// 11-base seed word scanner: sliding window over a 2-bit base stream,
// per-base equality against the loaded query, hit positions queued in a
// small FIFO drained over valid/ready.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; query/db_total latched on accepted start
//   SCAN  | accepting bases while the hit FIFO has room
//   DRAIN | stream finished; waiting for the hit FIFO to empty
//   DONE  | one-cycle done pulse, then back to IDLE
module blast_seed_scanner #(
    parameter int WORD_LEN   = 11,
    parameter int POS_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2*WORD_LEN-1:0] query,
    input  logic [POS_W-1:0]      db_total,
    blast_seed_scanner_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           hit_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(WORD_LEN + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(WORD_LEN);
    localparam logic [POS_W-1:0] ONE      = POS_W'(1);
    localparam logic [POS_W-1:0] BACK     = POS_W'(WORD_LEN - 1);
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [2*WORD_LEN-1:0] qword, win, win_nxt;
    logic [POS_W-1:0]      total, idx;
    logic [FW-1:0]         fill, fill_nxt;
    logic [POS_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  fifo_full, accept, hit, push, pop, start_ok;
    logic [WORD_LEN-1:0]   eq;

    assign fifo_full     = (count == CNT_FULL);
    assign bus.db_ready  = (state == SCAN) && !fifo_full;
    assign bus.hit_valid = (count != '0);
    assign bus.hit_pos   = bus.hit_valid ? mem[rd_ptr] : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    assign start_ok = (state == IDLE) && start && !abort;
    assign accept   = bus.db_valid && bus.db_ready && !abort;
    assign pop      = bus.hit_valid && bus.hit_ready && !abort;
    assign win_nxt  = {bus.db_base, win[2*WORD_LEN-1:2]};
    assign fill_nxt = (fill == FILL_MAX) ? fill : fill + FW'(1);
    assign hit      = accept && (&eq) && (fill_nxt == FILL_MAX);
    assign push     = hit;

    // Per-base equality of the shifted-in window against the query word.
    always_comb begin
        eq = '0;
        for (int i = 0; i < WORD_LEN; i++)
            eq[i] = (win_nxt[2*i +: 2] == qword[2*i +: 2]);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (db_total != '0) ? SCAN : DRAIN;
            SCAN:  if (accept && idx == total - ONE) state_nxt = DRAIN;
            DRAIN: if (count == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Scan context: latched query/length, window, fill count, base index, hit count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qword     <= '0;
            total     <= '0;
            win       <= '0;
            fill      <= '0;
            idx       <= '0;
            hit_count <= '0;
        end else if (start_ok) begin
            qword     <= query;
            total     <= db_total;
            win       <= '0;
            fill      <= '0;
            idx       <= '0;
            hit_count <= '0;
        end else if (accept) begin
            win  <= win_nxt;
            fill <= fill_nxt;
            idx  <= idx + ONE;
            if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end
    end

    // Hit FIFO storage; contents are only visible through hit_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= idx - BACK;
    end

    // Hit FIFO pointers and occupancy; abort flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_blast_seed_scanner.sv
// Directed bench for blast_seed_scanner: table of whole-scan vectors plus
// hand sequences for db_total 0, abort and mid-scan reset.
module tb_blast_seed_scanner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [21:0] query = '0;
    logic [31:0] db_total = '0;
    logic        busy, done;
    logic [15:0] hit_count;

    blast_seed_scanner_if #(.POS_W(32)) bus ();

    blast_seed_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .query(query), .db_total(db_total), .bus(bus),
        .busy(busy), .done(done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] q;
        int          pat;
        int          total;
        int          stall;
        int          exp_hits;
        int          exp_stall_acc;
    } vec_t;

    vec_t vecs [4];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // pat 0: all A. pat 1: T background, ACGTACGTACG at 5, one-base-off copy at 25.
    function automatic logic [1:0] base_at(input int pat, input int i);
        if (pat == 0) return 2'd0;
        if (i >= 5 && i < 16) return 2'((i - 5) % 4);
        if (i >= 25 && i < 36) return (i == 30) ? 2'd3 : 2'((i - 25) % 4);
        return 2'd3;
    endfunction

    function automatic logic [21:0] acgt_word();
        logic [21:0] w;
        w = '0;
        for (int j = 0; j < 11; j++) w[2*j +: 2] = 2'(j % 4);
        return w;
    endfunction

    task automatic pulse_start(input logic [21:0] q, input int total);
        query    = q;
        db_total = total;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic run_scan(input int v, input string tag);
        int exp_q[$];
        int idx, npop, ndone, cyc;
        logic ok;
        vec_t r;
        r = vecs[v];
        exp_q.delete();
        for (int s = 0; s + 11 <= r.total; s++) begin
            ok = 1'b1;
            for (int j = 0; j < 11; j++)
                if (base_at(r.pat, s + j) != r.q[2*j +: 2]) ok = 1'b0;
            if (ok) exp_q.push_back(s);
        end
        pulse_start(r.q, r.total);
        chk({tag, " busy after start"}, busy, 1);
        chk({tag, " db_ready after start"}, bus.db_ready, 1);
        idx = 0; npop = 0; ndone = 0; cyc = 0;
        while (ndone == 0 && cyc < 3000) begin
            bus.db_valid  = (idx < r.total);
            bus.db_base   = base_at(r.pat, idx);
            bus.hit_ready = (cyc >= r.stall);
            @(negedge clk);
            if (bus.db_valid && bus.db_ready) idx++;
            if (r.exp_stall_acc >= 0 && cyc == r.stall - 1) begin
                chk({tag, " bases accepted while stalled"}, idx, r.exp_stall_acc);
                chk({tag, " db_ready while full"}, bus.db_ready, 0);
            end
            if (bus.hit_valid && bus.hit_ready) begin
                if (npop < exp_q.size()) chk({tag, " hit_pos"}, bus.hit_pos, exp_q[npop]);
                else chk({tag, " unexpected extra hit_pos"}, bus.hit_pos, -1);
                npop++;
            end
            if (done) ndone++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.db_valid = 1'b0;
        chk({tag, " done seen within budget"}, ndone, 1);
        chk({tag, " hits popped"}, npop, r.exp_hits);
        chk({tag, " hit_count"}, hit_count, r.exp_hits);
        chk({tag, " bases accepted"}, idx, r.total);
        @(negedge clk);
        chk({tag, " done single cycle"}, done, 0);
        chk({tag, " busy after done"}, busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{q: 22'h0,       pat: 0, total: 20, stall: 0,  exp_hits: 10, exp_stall_acc: -1};
        vecs[1] = '{q: acgt_word(), pat: 1, total: 40, stall: 0,  exp_hits: 1,  exp_stall_acc: -1};
        vecs[2] = '{q: 22'h0,       pat: 0, total: 10, stall: 0,  exp_hits: 0,  exp_stall_acc: -1};
        vecs[3] = '{q: 22'h0,       pat: 0, total: 30, stall: 40, exp_hits: 20, exp_stall_acc: 18};
        bus.db_valid = 1'b0; bus.db_base = 2'd0; bus.hit_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset db_ready", bus.db_ready, 0);
        chk("reset hit_valid", bus.hit_valid, 0);
        chk("reset hit_pos", bus.hit_pos, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hit_count", hit_count, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) run_scan(v, $sformatf("vec%0d", v));

        // db_total == 0: DRAIN next cycle, done in the cycle after that.
        pulse_start(22'h0, 0);
        @(negedge clk);
        chk("zero busy k+1", busy, 1);
        chk("zero done k+1", done, 0);
        chk("zero hit_valid k+1", bus.hit_valid, 0);
        @(negedge clk);
        chk("zero done k+2", done, 1);
        chk("zero hit_valid k+2", bus.hit_valid, 0);
        @(negedge clk);
        chk("zero done k+3", done, 0);
        chk("zero busy k+3", busy, 0);
        @(posedge clk); #1;

        // Abort with three hits queued.
        bus.hit_ready = 1'b0;
        pulse_start(22'h0, 30);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 13; c++) begin
            bus.db_valid = 1'b1; bus.db_base = 2'd0;
            @(negedge clk);
            if (bus.db_ready) cnt++;
            @(posedge clk); #1;
        end
        bus.db_valid = 1'b0;
        chk("abort bases before abort", cnt, 13);
        chk("abort hits queued", hit_count, 3);
        abort = 1'b1; bus.db_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bus.db_valid = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort hit_valid", bus.hit_valid, 0);
        chk("abort db_ready", bus.db_ready, 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort no done", cnt, 0);
        @(posedge clk); #1;
        bus.hit_ready = 1'b1;
        run_scan(0, "post-abort");

        // Asynchronous reset mid-scan.
        bus.hit_ready = 1'b0;
        pulse_start(22'h0, 30);
        for (int c = 0; c < 14; c++) begin
            bus.db_valid = 1'b1; bus.db_base = 2'd0;
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset hit_valid", bus.hit_valid, 0);
        chk("mid reset hit_pos", bus.hit_pos, 0);
        chk("mid reset db_ready", bus.db_ready, 0);
        chk("mid reset hit_count", hit_count, 0);
        bus.db_valid = 1'b0; bus.hit_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        run_scan(1, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
